// File: rtl/m68k_bus_mem.sv
// 68030 asynchronous-bus slave memory with wait states, dynamic bus sizing and a byte preload port.
// Optional feature: define M68K_MEM_BERR_EN to bus-error accesses above the 2^ADDR_BITS window.
module m68k_bus_mem #(
    parameter int ADDR_BITS   = 12,
    parameter int PORT_WIDTH  = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                 CLK,
    input  logic                 RESET_INn,
    input  logic [31:0]          ADR_IN,
    input  logic [31:0]          WDATA,
    output logic [31:0]          RDATA,
    input  logic                 ASn,
    input  logic                 DSn,
    input  logic                 RWn,
    input  logic [1:0]           SIZE,
    output logic [1:0]           DSACKn,
    output logic                 BERRn,
    input  logic                 LOAD_WE,
    input  logic [ADDR_BITS-1:0] LOAD_ADR,
    input  logic [7:0]           LOAD_DATA
);
    localparam int P = PORT_WIDTH / 8;
    localparam logic [1:0] ACK_CODE = (PORT_WIDTH == 32) ? 2'b00 :
                                      (PORT_WIDTH == 16) ? 2'b01 : 2'b10;

    generate
        if (PORT_WIDTH != 32 && PORT_WIDTH != 16 && PORT_WIDTH != 8) begin : g_bad_pw
            $error("m68k_bus_mem: PORT_WIDTH must be 32, 16 or 8");
        end
    endgenerate

    typedef logic [ADDR_BITS-1:0] addr_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        commit;
    logic        bad;
    logic [7:0]  mem [2**ADDR_BITS];
    addr_t       idx, base;
    logic [1:0]  off;
    logic [2:0]  size_b, room, n;
    logic [31:0] rd_word;

    assign idx  = ADR_IN[ADDR_BITS-1:0];
    assign base = idx & ~addr_t'(P - 1);

`ifdef M68K_MEM_BERR_EN
    assign bad = |ADR_IN[31:ADDR_BITS];
`else
    logic unused_hi;
    assign unused_hi = ^ADR_IN[31:ADDR_BITS];
    assign bad       = 1'b0;
`endif

    // Bytes taken this cycle: requested size clipped at the end of the port.
    always_comb begin
        off    = ADR_IN[1:0] & 2'(P - 1);
        size_b = (SIZE == 2'b00) ? 3'd4 : {1'b0, SIZE};
        room   = 3'(P) - {1'b0, off};
        n      = (size_b < room) ? size_b : room;
    end

    // Port-aligned read word; lanes beyond the port width stay zero.
    always_comb begin
        rd_word = '0;
        for (int j = 0; j < P; j++)
            rd_word[8*(3-j) +: 8] = mem[base + addr_t'(j)];
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        commit  = 1'b0;
        case (state)
            S_IDLE: if (!ASn) begin
                state_d = S_WAIT;
                cnt_d   = 4'(WAIT_STATES);
            end
            S_WAIT: begin
                if (ASn) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else if (RWn || !DSn) begin
                    state_d = S_ACK;
                    commit  = 1'b1;
                end
            end
            S_ACK: if (ASn) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_INn) begin
        if (!RESET_INn) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            DSACKn <= 2'b11;
            BERRn  <= 1'b1;
            RDATA  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (commit) begin
                if (bad) begin
                    BERRn <= 1'b0;
                    RDATA <= '0;
                end else begin
                    DSACKn <= ACK_CODE;
                    RDATA  <= RWn ? rd_word : '0;
                end
            end else if (state == S_ACK && ASn) begin
                DSACKn <= 2'b11;
                BERRn  <= 1'b1;
                RDATA  <= '0;
            end
        end
    end

    // Preload is written last so it wins over a bus write to the same byte.
    always_ff @(posedge CLK) begin
        if (commit && !RWn && !bad) begin
            for (int k = 0; k < 4; k++)
                if (3'(k) < n)
                    mem[idx + addr_t'(k)] <= WDATA[8*(3 - int'(off) - k) +: 8];
        end
        if (LOAD_WE) mem[LOAD_ADR] <= LOAD_DATA;
    end
endmodule
